// File: rtl/fft64_r8_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft64_r8_sequencer_if
//  Brief    : Sample-side and result-side stream handshakes of the 64-point
//             radix-8 FFT sequencer, bundled with sequencer/environment views.
//  Revision : 1.0 - initial release
// ============================================================================
interface fft64_r8_sequencer_if #(
    parameter int DW = 32
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    // Sequencer view: consumes time samples, produces frequency samples
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    // Environment view: sources time samples, sinks frequency samples
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );
endinterface
`default_nettype wire

// File: rtl/fft64_r8_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fft64_r8_sequencer
//  Brief    : Buffers one 64-sample frame and runs it through a shared
//             combinational 8-point core as two radix-8 passes (columns with
//             twiddle, then rows), then streams the spectrum out.
//  Revision : 1.0 - initial release
// ============================================================================
module fft64_r8_sequencer #(
    parameter int DW        = 32,
    parameter bit NAT_ORDER = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    fft64_r8_sequencer_if.slave sif,
    output logic [8*DW-1:0]     core_xt,
    input  logic [8*DW-1:0]     core_xf,
    output logic                core_stage,
    output logic [2:0]          core_grp,
    output logic                busy
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_LOAD   = 3'd1;
    localparam logic [2:0] c_S_PASS_A = 3'd2;
    localparam logic [2:0] c_S_PASS_B = 3'd3;
    localparam logic [2:0] c_S_UNLOAD = 3'd4;

    localparam logic [5:0] c_LAST_IDX = 6'd63;
    localparam logic [2:0] c_LAST_GRP = 3'd7;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [5:0]    r_cnt;
    logic [5:0]    w_cnt_nxt;
    logic [2:0]    r_grp;
    logic [2:0]    w_grp_nxt;
    logic [DW-1:0] r_buf [64];

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_pass_a;
    logic          w_pass_b;
    logic          w_in_fire;
    logic          w_out_fire;
    logic [5:0]    w_rd_addr;

    // Decode handshake and core-control outputs from the registered state
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_pass_a    = 1'b0;
        w_pass_b    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            c_S_LOAD:   w_in_ready = 1'b1;
            c_S_PASS_A: begin
                w_pass_a = 1'b1;
                busy     = 1'b1;
            end
            c_S_PASS_B: begin
                w_pass_b = 1'b1;
                busy     = 1'b1;
            end
            c_S_UNLOAD: begin
                w_out_valid = 1'b1;
                busy        = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_in_fire  = sif.in_valid & w_in_ready;
    assign w_out_fire = w_out_valid & sif.out_ready;

    assign sif.in_ready  = w_in_ready;
    assign sif.out_valid = w_out_valid;
    assign sif.out_last  = w_out_valid & (r_cnt == c_LAST_IDX);
    assign sif.out_data  = w_out_valid ? r_buf[w_rd_addr] : '0;

    // Group index is a register, so stage/group stay aligned with core_xt
    assign core_stage = w_pass_b;
    assign core_grp   = r_grp;

    // Natural order reads the transposed address: j -> 8*(j mod 8) + j div 8
    if (NAT_ORDER) begin : g_nat_order
        assign w_rd_addr = {r_cnt[2:0], r_cnt[5:3]};
    end else begin : g_raw_order
        assign w_rd_addr = r_cnt;
    end

    // Core lane i reads a column element in pass A and a row element in pass B
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        localparam logic [2:0] c_LANE = 3'(gi);
        assign core_xt[DW*gi +: DW] = w_pass_a ? r_buf[{c_LANE, r_grp}] :
                                      w_pass_b ? r_buf[{r_grp, c_LANE}] : '0;
    end

    // Next-state and counter sequencing
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grp_nxt   = r_grp;
        case (r_state)
            c_S_IDLE: begin
                if (en) begin
                    w_state_nxt = c_S_LOAD;
                end
            end
            c_S_LOAD: begin
                if (w_in_fire) begin
                    w_cnt_nxt = r_cnt + 6'd1;
                    if (r_cnt == c_LAST_IDX) begin
                        w_state_nxt = c_S_PASS_A;
                    end
                end
            end
            c_S_PASS_A: begin
                w_grp_nxt = r_grp + 3'd1;
                if (r_grp == c_LAST_GRP) begin
                    w_state_nxt = c_S_PASS_B;
                end
            end
            c_S_PASS_B: begin
                w_grp_nxt = r_grp + 3'd1;
                if (r_grp == c_LAST_GRP) begin
                    w_state_nxt = c_S_UNLOAD;
                end
            end
            c_S_UNLOAD: begin
                if (w_out_fire) begin
                    w_cnt_nxt = r_cnt + 6'd1;
                    if (r_cnt == c_LAST_IDX) begin
                        w_state_nxt = en ? c_S_LOAD : c_S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_cnt_nxt   = '0;
                w_grp_nxt   = '0;
            end
        endcase
    end

    // State and counter registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_grp   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grp   <= w_grp_nxt;
        end
    end

    // In-place frame buffer: sample loads, then core results written back
    // to the same addresses they were read from
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_buf[r_cnt] <= sif.in_data;
        end else if (w_pass_a) begin
            for (int k = 0; k < 8; k++) begin
                r_buf[{3'(k), r_grp}] <= core_xf[DW*k +: DW];
            end
        end else if (w_pass_b) begin
            for (int k = 0; k < 8; k++) begin
                r_buf[{r_grp, 3'(k)}] <= core_xf[DW*k +: DW];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft64_r8_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft64_r8_sequencer
//  Brief    : Scoreboard bench for the 64-point radix-8 FFT sequencer with an
//             identity core and an ideal rounded 8-point DFT + twiddle core.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fft64_r8_sequencer;

    localparam int  DW   = 32;
    localparam real c_PI = 3.14159265358979323846;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [8*DW-1:0] core_xt;
    logic [8*DW-1:0] core_xf;
    logic            core_stage;
    logic [2:0]      core_grp;
    logic            busy;

    logic            core_mode;   // 0 = identity core, 1 = ideal DFT core
    logic            bp_on;
    int              checks   = 0;
    int              failures = 0;
    int              edge_cnt = 0;
    int              last_in_edge = 0;
    bit              lat_check = 1'b0;
    bit              prev_valid = 1'b0;
    bit              stall_pend = 1'b0;
    logic [DW-1:0]   held_data;
    logic            held_last;
    logic [DW:0]     exp_q [$];
    logic [DW-1:0]   frame_x [64];

    fft64_r8_sequencer_if #(.DW(DW)) sif ();

    fft64_r8_sequencer #(.DW(DW), .NAT_ORDER(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sif        (sif),
        .core_xt    (core_xt),
        .core_xf    (core_xf),
        .core_stage (core_stage),
        .core_grp   (core_grp),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [8*DW-1:0] act, input logic [8*DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    // Ideal 8-point DFT with rounding, followed in stage 0 by W64^(grp*k)
    function automatic logic [8*DW-1:0] core_fn(input logic [8*DW-1:0] xt,
                                                input logic stage, input logic [2:0] grp);
        logic [8*DW-1:0] res;
        logic signed [15:0] sr, si;
        real re, im, ang, tr, ti;
        int r1, i1;
        res = '0;
        for (int k = 0; k < 8; k++) begin
            re = 0.0;
            im = 0.0;
            for (int n = 0; n < 8; n++) begin
                sr  = xt[DW*n+16 +: 16];
                si  = xt[DW*n +: 16];
                ang = -2.0 * c_PI * real'(n * k) / 8.0;
                re += $itor(sr) * $cos(ang) - $itor(si) * $sin(ang);
                im += $itor(sr) * $sin(ang) + $itor(si) * $cos(ang);
            end
            r1 = rnd(re);
            i1 = rnd(im);
            if (!stage) begin
                ang = -2.0 * c_PI * real'(int'(grp) * k) / 64.0;
                tr  = $itor(r1) * $cos(ang) - $itor(i1) * $sin(ang);
                ti  = $itor(r1) * $sin(ang) + $itor(i1) * $cos(ang);
                r1  = rnd(tr);
                i1  = rnd(ti);
            end
            res[DW*k +: DW] = {r1[15:0], i1[15:0]};
        end
        return res;
    endfunction

    always_comb core_xf = core_mode ? core_fn(core_xt, core_stage, core_grp) : core_xt;

    // Reference: 64-point FFT as x[n1+8*n2] -> column DFTs (twiddled by n1*k2)
    // -> row DFTs, X[k2+8*k1]; queued in natural k order
    task automatic push_fft_ref();
        logic [DW-1:0]   y [64];
        logic [DW-1:0]   xk [64];
        logic [8*DW-1:0] v, w;
        for (int n1 = 0; n1 < 8; n1++) begin
            for (int n2 = 0; n2 < 8; n2++) v[DW*n2 +: DW] = frame_x[n1 + 8*n2];
            w = core_fn(v, 1'b0, 3'(n1));
            for (int k2 = 0; k2 < 8; k2++) y[8*n1 + k2] = w[DW*k2 +: DW];
        end
        for (int k2 = 0; k2 < 8; k2++) begin
            for (int n1 = 0; n1 < 8; n1++) v[DW*n1 +: DW] = y[8*n1 + k2];
            w = core_fn(v, 1'b1, 3'(k2));
            for (int k1 = 0; k1 < 8; k1++) xk[k2 + 8*k1] = w[DW*k1 +: DW];
        end
        for (int k = 0; k < 64; k++) exp_q.push_back({k == 63, xk[k]});
    endtask

    task automatic random_frame();
        int re, im;
        for (int j = 0; j < 64; j++) begin
            re = int'($urandom_range(0, 200)) - 100;
            im = int'($urandom_range(0, 200)) - 100;
            frame_x[j] = {re[15:0], im[15:0]};
        end
    endtask

    // Drives frame_x with random in_valid gaps; optionally leaves in_valid
    // high with junk afterwards. Called and returns at posedge+1.
    task automatic send_frame(input bit hold_junk);
        int  idx   = 0;
        int  guard = 0;
        bit  hs;
        while (idx < 64) begin
            sif.in_valid = ($urandom_range(0, 3) != 0);
            sif.in_data  = sif.in_valid ? frame_x[idx] : $urandom;
            @(negedge clk);
            hs = sif.in_valid && sif.in_ready;
            @(posedge clk);
            #1;
            if (hs) idx++;
            guard++;
            if (guard > 4000) begin
                check("send_timeout_beats", idx, 64);
                break;
            end
        end
        sif.in_valid = hold_junk;
        sif.in_data  = 32'hDEAD_BEEF;
        last_in_edge = edge_cnt;
        lat_check    = 1'b1;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 4000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_queue_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Backpressure source, updated just after each active edge
    always @(posedge clk) begin
        #1;
        sif.out_ready = bp_on ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Monitor: samples mid-cycle, compares each pending handshake against the
    // scoreboard, checks hold-stability during stalls and first-output latency
    always @(negedge clk) begin
        logic [DW:0] e;
        if (sif.out_valid && !prev_valid && lat_check) begin
            check("first_out_latency", edge_cnt - last_in_edge, 16);
            lat_check = 1'b0;
        end
        if (stall_pend && sif.out_valid) begin
            check("stall_data_hold", sif.out_data, held_data);
            check("stall_last_hold", sif.out_last, held_last);
        end
        if (sif.out_valid && sif.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_output actual=%0h required=no_output", sif.out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", sif.out_data, e[DW-1:0]);
                check("out_last", sif.out_last, e[DW]);
            end
        end
        stall_pend = sif.out_valid && !sif.out_ready;
        held_data  = sif.out_data;
        held_last  = sif.out_last;
        prev_valid = sif.out_valid;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        en            = 1'b0;
        core_mode     = 1'b0;
        bp_on         = 1'b0;
        sif.in_valid  = 1'b0;
        sif.in_data   = '0;
        sif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_in_ready", sif.in_ready, 0);
        check("rst_out_valid", sif.out_valid, 0);
        check("rst_out_last", sif.out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_core_stage", core_stage, 0);
        check("rst_core_grp", core_grp, 0);
        check("rst_out_data", sif.out_data, 0);
        check("rst_core_xt", core_xt, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_en_in_ready", sif.in_ready, 0);

        // Identity core: output j carries 8*(j mod 8) + j div 8
        en = 1'b1;
        for (int j = 0; j < 64; j++) begin
            frame_x[j] = 32'(j);
            exp_q.push_back({j == 63, 32'(8 * (j % 8) + j / 8)});
        end
        send_frame(1'b0);
        wait_drain();

        // Ideal core: impulse -> flat spectrum
        core_mode = 1'b1;
        for (int j = 0; j < 64; j++) begin
            frame_x[j] = (j == 0) ? 32'h0100_0000 : 32'h0;
            exp_q.push_back({j == 63, 32'h0100_0000});
        end
        send_frame(1'b0);
        wait_drain();

        // Ideal core: constant -> single DC bin of 64
        for (int j = 0; j < 64; j++) begin
            frame_x[j] = 32'h0001_0000;
            exp_q.push_back({j == 63, (j == 0) ? 32'h0040_0000 : 32'h0});
        end
        send_frame(1'b0);
        wait_drain();

        // Two random frames back to back under backpressure
        bp_on = 1'b1;
        random_frame();
        push_fft_ref();
        send_frame(1'b0);
        random_frame();
        push_fft_ref();
        send_frame(1'b0);
        wait_drain();

        // Reset in the middle of pass B aborts the frame
        random_frame();
        send_frame(1'b0);
        repeat (12) @(posedge clk);
        #1;
        check("passb_core_stage", core_stage, 1);
        check("passb_core_grp", core_grp, 4);
        check("passb_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        lat_check = 1'b0;
        check("midrst_in_ready", sif.in_ready, 0);
        check("midrst_out_valid", sif.out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_core_xt", core_xt, 0);
        rst_n = 1'b1;
        random_frame();
        push_fft_ref();
        send_frame(1'b0);
        wait_drain();

        // en low at end of unload returns to IDLE; junk in_valid is ignored
        random_frame();
        push_fft_ref();
        send_frame(1'b1);
        en = 1'b0;
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        check("en_low_idle_in_ready", sif.in_ready, 0);
        check("en_low_idle_busy", busy, 0);
        sif.in_valid = 1'b0;
        en = 1'b1;
        @(posedge clk);
        #1;
        check("en_high_in_ready", sif.in_ready, 1);

        // One more frame to confirm clean restart
        random_frame();
        push_fft_ref();
        send_frame(1'b0);
        wait_drain();

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
